// File: rtl/vga_char_sync.sv
// ============================================================================
//  Module   : vga_char_sync
//  Purpose  : Character-rate 800x600@60 VGA timing. Produces the char/line
//             counters, registered hsync/vsync and a look-ahead visible flag.
//             Optional FRAME_COUNT_EN adds a 16-bit completed-frame counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_char_sync #(
    parameter int H_VISIBLE = 100,
    parameter int H_FRONT   = 5,
    parameter int H_SYNC    = 16,
    parameter int H_BACK    = 11,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1
) (
    input  logic        char_clock,
    input  logic        reset,
    output logic [7:0]  char_count,
    output logic [11:0] line_count,
    output logic        pre_visible,
    output logic        hsync,
    output logic        vsync,
`ifdef FRAME_COUNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [7:0]  c_h_last     = 8'(H_TOTAL - 1);
    localparam logic [7:0]  c_h_visible  = 8'(H_VISIBLE);
    localparam logic [7:0]  c_hs_start   = 8'(H_VISIBLE + H_FRONT);
    localparam logic [7:0]  c_hs_end     = 8'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [11:0] c_v_last     = 12'(V_TOTAL - 1);
    localparam logic [11:0] c_v_visible  = 12'(V_VISIBLE);
    localparam logic [11:0] c_vs_start   = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] c_vs_end     = 12'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [7:0]  r_char_count;
    logic [11:0] r_line_count;
    logic        r_hsync;
    logic        r_vsync;
    logic        w_char_wrap;
    logic        w_line_wrap;
    logic        w_hsync_next;
    logic        w_vsync_next;

    assign w_char_wrap  = (r_char_count == c_h_last);
    assign w_line_wrap  = (r_line_count == c_v_last);
    assign w_hsync_next = ((r_char_count >= c_hs_start) && (r_char_count < c_hs_end)) ? H_POL : ~H_POL;
    assign w_vsync_next = ((r_line_count >= c_vs_start) && (r_line_count < c_vs_end)) ? V_POL : ~V_POL;

    always_ff @(posedge char_clock) begin
        if (reset) begin
            r_char_count <= '0;
            r_line_count <= '0;
            r_hsync      <= ~H_POL;
            r_vsync      <= ~V_POL;
        end else begin
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            if (w_char_wrap) begin
                r_char_count <= '0;
                r_line_count <= w_line_wrap ? 12'd0 : r_line_count + 12'd1;
            end else begin
                r_char_count <= r_char_count + 8'd1;
            end
        end
    end

`ifdef FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    // Counts on the (H_TOTAL-1,V_TOTAL-1)->(0,0) transition; wraps naturally at 16 bits.
    always_ff @(posedge char_clock) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_char_wrap && w_line_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign char_count  = r_char_count;
    assign line_count  = r_line_count;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pre_visible = (r_char_count < c_h_visible) && (r_line_count < c_v_visible);
    assign frame_start = (r_char_count == 8'd0) && (r_line_count == 12'd0);

endmodule

`default_nettype wire

// File: tb/tb_vga_char_sync.sv
// ============================================================================
//  Module   : tb_vga_char_sync
//  Purpose  : Directed self-checking bench for vga_char_sync (default params).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_char_sync;

    logic        char_clock = 1'b0;
    logic        reset      = 1'b1;
    logic [7:0]  char_count;
    logic [11:0] line_count;
    logic        pre_visible;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
`ifdef FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    vga_char_sync dut (
        .char_clock  (char_clock),
        .reset       (reset),
        .char_count  (char_count),
        .line_count  (line_count),
        .pre_visible (pre_visible),
        .hsync       (hsync),
        .vsync       (vsync),
`ifdef FRAME_COUNT_EN
        .frame_count (frame_count),
`endif
        .frame_start (frame_start)
    );

    always #5 char_clock = ~char_clock;

    int   checks   = 0;
    int   failures = 0;
    int   exp_c    = 0;
    int   exp_l    = 0;
    logic exp_h    = 1'b0;
    logic exp_v    = 1'b0;
    int   exp_fc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (pos %0d,%0d)", tag, got, exp, exp_c, exp_l);
        end
    endtask

    // Advance one char clock and update the reference timing model.
    task automatic step();
        @(posedge char_clock);
        #1;
        if (reset) begin
            exp_c  = 0;
            exp_l  = 0;
            exp_h  = 1'b0;
            exp_v  = 1'b0;
            exp_fc = 0;
        end else begin
            exp_h = (exp_c >= 105) && (exp_c <= 120);
            exp_v = (exp_l >= 601) && (exp_l <= 604);
            if (exp_c == 131) begin
                exp_c = 0;
                if (exp_l == 627) begin
                    exp_l  = 0;
                    exp_fc = (exp_fc + 1) % 65536;
                end else begin
                    exp_l = exp_l + 1;
                end
            end else begin
                exp_c = exp_c + 1;
            end
        end
    endtask

    task automatic check_state();
        chk("char_count",  32'(char_count),  32'(exp_c));
        chk("line_count",  32'(line_count),  32'(exp_l));
        chk("pre_visible", 32'(pre_visible), 32'((exp_c < 100) && (exp_l < 600)));
        chk("hsync",       32'(hsync),       32'(exp_h));
        chk("vsync",       32'(vsync),       32'(exp_v));
        chk("frame_start", 32'(frame_start), 32'((exp_c == 0) && (exp_l == 0)));
`ifdef FRAME_COUNT_EN
        chk("frame_count", 32'(frame_count), 32'(exp_fc));
`endif
    endtask

    int   vis_cnt, hs_cnt, vs_cnt, vs_rise, fs_cnt, overlap;
    logic prev_v;

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_char",  32'(char_count),  32'd0);
        chk("rst_line",  32'(line_count),  32'd0);
        chk("rst_vis",   32'(pre_visible), 32'd1);
        chk("rst_fs",    32'(frame_start), 32'd1);
        chk("rst_hsync", 32'(hsync),       32'd0);
        chk("rst_vsync", 32'(vsync),       32'd0);

        // Run into line 3, char 57 with full per-cycle checking
        reset = 1'b0;
        for (int i = 0; i < 3 * 132 + 57; i++) begin
            step();
            check_state();
        end
        chk("mid_char", 32'(char_count), 32'd57);
        chk("mid_line", 32'(line_count), 32'd3);

        // Mid-frame reset for 3 cycles
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rel_char",  32'(char_count),  32'd0);
        chk("rel_line",  32'(line_count),  32'd0);
        chk("rel_hsync", 32'(hsync),       32'd0);
        chk("rel_vsync", 32'(vsync),       32'd0);
        chk("rel_vis",   32'(pre_visible), 32'd1);

        // One full frame of 82896 char cycles starting at (0,0)
        vis_cnt = 0; hs_cnt = 0; vs_cnt = 0; vs_rise = 0; fs_cnt = 0; overlap = 0;
        prev_v = vsync;
        for (int i = 0; i < 132 * 628; i++) begin
            check_state();
            if (pre_visible) vis_cnt++;
            if (hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (vsync && !prev_v) vs_rise++;
            if (frame_start) fs_cnt++;
            if (hsync && pre_visible) overlap++;
            prev_v = vsync;
            step();
        end
        check_state();
        chk("frame_vis_cycles",   32'(vis_cnt), 32'd60000);
        chk("frame_hsync_cycles", 32'(hs_cnt),  32'd10048);
        chk("frame_vsync_cycles", 32'(vs_cnt),  32'd528);
        chk("frame_vsync_rises",  32'(vs_rise), 32'd1);
        chk("frame_start_pulses", 32'(fs_cnt),  32'd1);
        chk("hsync_in_visible",   32'(overlap), 32'd0);
        chk("wrap_frame_start",   32'(frame_start), 32'd1);
`ifdef FRAME_COUNT_EN
        chk("frame_count_after",  32'(frame_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
